oreg_bank_sched: RTL
====================

# oreg_bank_sched

Scheduler and arbiter for a bank of `WIDTH` ECP5 output-register cells (D / SP / PD flops with clock-enable and preset). It shares the bank between `NREQ` requesters with round-robin arbitration, turns each grant into a per-bit D/SP update, and sequences the preset (PD) path for reset and forced-park conditions. It sits between core logic and the I/O-cell flops, which it drives directly on `SCLK`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: output-register bits in the bank.
- `PARK_CYCLES`, 4: minimum PD assertion length in cycles, ≥1.

- `SCLK`  in  1  clock; also clocks the output-register cells.
- `RSTN`  in  1  reset; asynchronous, active-low.
- `req`  in  NREQ  update request, one bit per requester; held high until granted.
- `req_data`  in  NREQ*WIDTH  per-requester value; requester i uses slice [i*WIDTH +: WIDTH].
- `req_mask`  in  NREQ*WIDTH  per-requester bit-enable, same slicing.
- `park`  in  1  level; forces every bank bit high via PD.
- `gnt`  out  NREQ  one-hot, single-cycle grant pulse.
- `oreg_d`  out  WIDTH  D to the cells.
- `oreg_sp`  out  WIDTH  SP (clock enable) to the cells.
- `oreg_pd`  out  WIDTH  PD (preset) to the cells.
- `shadow_q`  out  WIDTH  expected cell Q after the current cycle's edge.
- `parked`  out  1  high while in RST_PARK or PARK.

## Operation
- All outputs are registered. Reset values: `gnt`=0, `oreg_d`=0, `oreg_sp`=0, `oreg_pd`=all ones, `shadow_q`=all ones, `parked`=1, RR pointer=NREQ-1, state=RST_PARK, park counter=0.
- States:
  - RST_PARK: entered on reset. PD stays asserted for `PARK_CYCLES` cycles after `RSTN` deasserts, then the block goes to PARK if `park`=1, otherwise to RUN.
  - RUN: the arbiter is active and PD is low. If `park`=1, the block goes to PARK. This check has priority over requests.
  - PARK: `oreg_pd`=all ones, `oreg_sp`=0, and no grants are issued. The block stays for at least `PARK_CYCLES` cycles and until `park`=0, then returns to RUN. `shadow_q` is all ones throughout.
- Arbitration in RUN:
  - Eligible requesters are those with `req`=1, excluding any requester whose `gnt` is high in the current cycle.
  - The winner is the first eligible index after the RR pointer, wrapping modulo NREQ.
  - At the next edge, the block registers `gnt[w]`=1, `oreg_d`=`req_data[w]`, and `oreg_sp`=`req_mask[w]`. It sets the pointer to w and updates `shadow_q` = (`shadow_q` & ~mask) | (data & mask).
- No eligible requester: `gnt`=0 and `oreg_sp`=0. `oreg_d` holds its last value.
- A zero mask still produces a grant, but `shadow_q` does not change.
- Requests dropped before their grant are lost; no grant is issued for them.

## Timing
- Latency: a request sampled at edge N produces `gnt` and D/SP in the cycle after edge N. The cells capture that value at edge N+1.
- Throughput: one grant per cycle. With all requesters held high, the grant order is 0,1,…,NREQ-1,0,…
- `park` rising in the same cycle as a request: at the next edge `oreg_pd` goes high, `oreg_sp` goes low, and no grant is issued. The request stays pending.
- A grant already registered when `park` rises still completes its SP cycle in that cycle. PD follows on the next cycle.
- `park` pulses shorter than `PARK_CYCLES` still produce `PARK_CYCLES` cycles of PD.
- Reset asserted mid-operation forces the reset values immediately (asynchronously), including PD high. The RR pointer restarts at NREQ-1.
- On leaving PARK, the first grant appears no earlier than the cycle after `parked` falls.

## Structure
- Shared package `oreg_sched_pkg` holds:
  - enum `oreg_state_t` {RST_PARK, PARK, RUN}
  - localparam for the counter width, $clog2(PARK_CYCLES+1)
  - function `rr_pick(req, ptr)` returning a one-hot winner
- One sub-module, `oreg_rr_arb`: combinational round-robin pick with a registered pointer. The top level holds the FSM, the park counter, the shadow register, and the output registers.

## Test plan
- Reset: `RSTN` low then high with NREQ=4, WIDTH=8, PARK_CYCLES=4 → `oreg_pd`=8'hFF and `parked`=1 for 4 cycles after release; then `oreg_pd`=0 and `parked`=0.
- Single update: requester 2 with data=8'hA5, mask=8'h0F, from `shadow_q`=8'hFF → `gnt`=4'b0100 one cycle later, `oreg_sp`=8'h0F, `oreg_d`=8'hA5, `shadow_q`=8'hF5.
- Fairness: all four `req` held high for 8 cycles → grant sequence 0,1,2,3,0,1,2,3, with no repeated grant to the same requester in consecutive cycles.
- Park collision: `park` and req[1] rise together → no grant; PD high for at least 4 cycles. Release `park` → `gnt[1]` appears after `parked` falls; `shadow_q` = 8'hFF merged with req[1]'s data.
- Short park: 1-cycle `park` pulse → PD held exactly 4 cycles, then RUN.
- Reset mid-grant: `RSTN` low in the cycle `gnt`=4'b0010 → `gnt`=0, `oreg_sp`=0, `oreg_pd`=8'hFF immediately. The first grant after the restart goes to requester 0.

Source files
------------

// File: rtl/oreg_sched_pkg.sv
// Shared types, constants and the round-robin pick function for the
// output-register bank scheduler.
package oreg_sched_pkg;

  typedef enum logic [1:0] {
    RST_PARK,
    PARK,
    RUN
  } oreg_state_t;

  // Widest requester vector the pick function handles. Narrower vectors are
  // zero-extended. The padding bits never win, so a modulo-8 search visits
  // the real requesters in the same order as a modulo-NREQ search.
  localparam int MAX_NREQ = 8;

  localparam int DEF_PARK_CYCLES = 4;
  localparam int PARK_CNT_W      = $clog2(DEF_PARK_CYCLES + 1);

  // One-hot winner: the first set bit of req strictly after ptr, wrapping.
  function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                                  input logic [2:0]          ptr);
    logic [MAX_NREQ-1:0] pick;
    logic [2:0]          idx;
    pick = '0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      idx = ptr + 3'(k);
      if (req[idx] && (pick == '0)) pick[idx] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/oreg_bank_sched_rr_arb.sv
// Round-robin arbiter: combinational pick against a registered pointer that
// moves to the winner whenever the top level takes a grant.
module oreg_rr_arb
  import oreg_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_elig,
  input  logic            i_adv,
  output logic [NREQ-1:0] o_win,
  output logic            o_any
);

  logic [2:0]          r_ptr;
  logic [MAX_NREQ-1:0] w_pick;
  logic [2:0]          w_idx;

  assign w_pick = rr_pick(MAX_NREQ'(i_elig), r_ptr);
  assign o_win  = w_pick[NREQ-1:0];
  assign o_any  = |w_pick;

  // Encode the one-hot winner into the index stored as the new pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (w_pick[i]) w_idx = 3'(i);
    end
  end

  // Pointer starts at the last requester so requester 0 is favoured first.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values, regardless of statement order.
    if (!rst_n) begin
      r_ptr <= 3'(NREQ - 1);
    end else if (i_adv && o_any) begin
      r_ptr <= w_idx;
    end
  end

endmodule

// File: rtl/oreg_bank_sched.sv
// Shares a bank of output-register cells between requesters, turns grants
// into D/SP updates and sequences PD for reset and forced park.
module oreg_bank_sched
  import oreg_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int PARK_CYCLES = DEF_PARK_CYCLES
) (
  input  logic                  SCLK,
  input  logic                  RSTN,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*WIDTH-1:0] req_mask,
  input  logic                  park,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      oreg_d,
  output logic [WIDTH-1:0]      oreg_sp,
  output logic [WIDTH-1:0]      oreg_pd,
  output logic [WIDTH-1:0]      shadow_q,
  output logic                  parked
);

  localparam int                CNT_W    = $clog2(PARK_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(PARK_CYCLES - 1);

  oreg_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic [WIDTH-1:0] r_d, w_d_nxt;
  logic [WIDTH-1:0] r_sp, w_sp_nxt;
  logic [WIDTH-1:0] r_pd, w_pd_nxt;
  logic [WIDTH-1:0] r_shadow, w_shadow_nxt;
  logic             r_parked, w_parked_nxt;

  logic [NREQ-1:0]  w_elig, w_win;
  logic             w_any, w_adv;
  logic [WIDTH-1:0] w_sel_data, w_sel_mask;

  // A requester whose grant is showing this cycle is not considered again.
  assign w_elig = req & ~r_gnt;

  oreg_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk    (SCLK),
    .rst_n  (RSTN),
    .i_elig (w_elig),
    .i_adv  (w_adv),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  // One-hot mux of the winner's data and mask slices.
  always_comb begin
    w_sel_data = '0;
    w_sel_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_sel_data = w_sel_data | req_data[i*WIDTH +: WIDTH];
        w_sel_mask = w_sel_mask | req_mask[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state and next output values; defaults describe a parked bank.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_gnt_nxt    = '0;
    w_d_nxt      = r_d;
    w_sp_nxt     = '0;
    w_pd_nxt     = '1;
    w_shadow_nxt = '1;
    w_parked_nxt = 1'b1;
    w_adv        = 1'b0;
    case (r_state)
      RST_PARK, PARK: begin
        if (r_cnt != CNT_DONE) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else if (!park) begin
          // Leave with no grant on this edge; arbitration restarts next cycle.
          w_state_nxt  = RUN;
          w_pd_nxt     = '0;
          w_parked_nxt = 1'b0;
        end else begin
          w_state_nxt = PARK;
        end
      end
      RUN: begin
        w_pd_nxt     = '0;
        w_parked_nxt = 1'b0;
        w_shadow_nxt = r_shadow;
        if (park) begin
          // Park wins over any request; the request stays pending.
          w_state_nxt  = PARK;
          w_cnt_nxt    = '0;
          w_pd_nxt     = '1;
          w_parked_nxt = 1'b1;
          w_shadow_nxt = '1;
        end else if (w_any) begin
          w_adv        = 1'b1;
          w_gnt_nxt    = w_win;
          w_d_nxt      = w_sel_data;
          w_sp_nxt     = w_sel_mask;
          w_shadow_nxt = (r_shadow & ~w_sel_mask) | (w_sel_data & w_sel_mask);
        end
      end
      default: begin
        w_state_nxt = RST_PARK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, park counter and all registered outputs.
  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state  <= RST_PARK;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_d      <= '0;
      r_sp     <= '0;
      r_pd     <= '1;
      r_shadow <= '1;
      r_parked <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gnt    <= w_gnt_nxt;
      r_d      <= w_d_nxt;
      r_sp     <= w_sp_nxt;
      r_pd     <= w_pd_nxt;
      r_shadow <= w_shadow_nxt;
      r_parked <= w_parked_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign oreg_d   = r_d;
  assign oreg_sp  = r_sp;
  assign oreg_pd  = r_pd;
  assign shadow_q = r_shadow;
  assign parked   = r_parked;

endmodule
